// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - data-side bridge from the memory-stage aligner to an SRAM-like data bus
module dmem_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        memenM,
    input  logic [3:0]  memwenM,
    input  logic [1:0]  sizeM,
    input  logic [31:0] addrM,
    input  logic [31:0] realwdataM,
    input  logic        flushM,
    input  logic        pipe_stall,
    output logic        stallM,
    output logic [31:0] readdataM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state, state_nxt;
    logic        start;
    logic        req_comb, stall_comb;
    logic        is_idle;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic [31:0] rbuf;

    assign start   = memenM & ~flushM;
    assign is_idle = (state == IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rbuf      <= '0;
            req_wr    <= 1'b0;
            req_size  <= '0;
            req_addr  <= '0;
            req_wstrb <= '0;
            req_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (is_idle && start) begin
                req_wr    <= |memwenM;
                req_size  <= sizeM;
                req_addr  <= addrM;
                req_wstrb <= memwenM;
                req_wdata <= realwdataM;
            end
            if (state == DATA && data_data_ok) begin
                rbuf <= data_rdata;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        req_comb   = 1'b0;
        stall_comb = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    req_comb   = 1'b1;
                    stall_comb = 1'b1;
                    state_nxt  = data_addr_ok ? DATA : ADDR;
                end
            end
            ADDR: begin
                req_comb   = 1'b1;
                stall_comb = 1'b1;
                if (data_addr_ok) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (data_data_ok) begin
                    // Park in DONE while frozen so the instruction still in M is not re-issued.
                    state_nxt = pipe_stall ? DONE : IDLE;
                end else begin
                    stall_comb = 1'b1;
                end
            end
            DONE: begin
                if (!pipe_stall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gate with resetn so the bus sees no request while reset is asserted.
    assign data_req   = req_comb & resetn;
    assign stallM     = stall_comb & resetn;

    assign data_wr    = is_idle ? |memwenM  : req_wr;
    assign data_size  = is_idle ? sizeM      : req_size;
    assign data_addr  = is_idle ? addrM      : req_addr;
    assign data_wstrb = is_idle ? memwenM    : req_wstrb;
    assign data_wdata = is_idle ? realwdataM : req_wdata;

    assign readdataM  = (state == DATA && data_data_ok) ? data_rdata : rbuf;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - self-checking bench for dmem_bridge
module tb_dmem_bridge;

    logic        clk;
    logic        resetn;
    logic        memenM;
    logic [3:0]  memwenM;
    logic [1:0]  sizeM;
    logic [31:0] addrM;
    logic [31:0] realwdataM;
    logic        flushM;
    logic        pipe_stall;
    logic        stallM;
    logic [31:0] readdataM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] last_rdata = 32'h0;

    dmem_bridge dut (
        .clk          (clk),
        .resetn       (resetn),
        .memenM       (memenM),
        .memwenM      (memwenM),
        .sizeM        (sizeM),
        .addrM        (addrM),
        .realwdataM   (realwdataM),
        .flushM       (flushM),
        .pipe_stall   (pipe_stall),
        .stallM       (stallM),
        .readdataM    (readdataM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fields(input string tag, input logic [3:0] ws, input logic [1:0] sz,
                              input logic [31:0] ad, input logic [31:0] wd);
        chk({tag, "_wr"},    {31'h0, data_wr},    {31'h0, |ws});
        chk({tag, "_size"},  {30'h0, data_size},  {30'h0, sz});
        chk({tag, "_addr"},  data_addr,           ad);
        chk({tag, "_wstrb"}, {28'h0, data_wstrb}, {28'h0, ws});
        chk({tag, "_wdata"}, data_wdata,          wd);
    endtask

    // One memory instruction in M: aw cycles waiting for addr_ok, dw cycles waiting for
    // data_ok, then ps cycles of frozen pipeline (last one releases) after completion.
    task automatic do_txn(input logic [3:0] ws, input logic [31:0] ad, input logic [1:0] sz,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int aw, input int dw, input int ps, input bit flush_addr);
        cyc();
        memenM = 1'b1; memwenM = ws; sizeM = sz; addrM = ad; realwdataM = wd;
        flushM = 1'b0; pipe_stall = 1'($urandom_range(0, 1));
        data_addr_ok = (aw == 0); data_data_ok = 1'b0; data_rdata = $urandom;
        #1;
        chk("issue_req", {31'h0, data_req}, 32'h1);
        chk("issue_stall", {31'h0, stallM}, 32'h1);
        chk_fields("issue", ws, sz, ad, wd);
        for (int i = 1; i <= aw; i++) begin
            cyc();
            memwenM = 4'($urandom); sizeM = 2'($urandom); addrM = $urandom;
            realwdataM = $urandom; flushM = flush_addr;
            pipe_stall = 1'($urandom_range(0, 1));
            data_addr_ok = (i == aw); data_rdata = $urandom;
            #1;
            chk("wait_req", {31'h0, data_req}, 32'h1);
            chk("wait_stall", {31'h0, stallM}, 32'h1);
            chk_fields("held", ws, sz, ad, wd);
        end
        for (int j = 0; j <= dw; j++) begin
            cyc();
            data_addr_ok = 1'b0;
            data_data_ok = (j == dw);
            data_rdata = (j == dw) ? rd : $urandom;
            pipe_stall = (j == dw) ? (ps > 0) : 1'($urandom_range(0, 1));
            #1;
            chk("data_req", {31'h0, data_req}, 32'h0);
            chk("data_stall", {31'h0, stallM}, {31'h0, j != dw});
            chk("data_rdata", readdataM, (j == dw) ? rd : last_rdata);
        end
        last_rdata = rd;
        for (int k = 1; k <= ps; k++) begin
            cyc();
            memenM = 1'b1; flushM = 1'b0; pipe_stall = (k < ps);
            data_data_ok = 1'($urandom_range(0, 1)); data_rdata = $urandom;
            #1;
            chk("done_req", {31'h0, data_req}, 32'h0);
            chk("done_stall", {31'h0, stallM}, 32'h0);
            chk("done_rdata", readdataM, last_rdata);
        end
    endtask

    task automatic gap();
        cyc();
        memenM = 1'b0; flushM = 1'b0; pipe_stall = 1'($urandom_range(0, 1));
        data_addr_ok = 1'($urandom_range(0, 1)); data_data_ok = 1'($urandom_range(0, 1));
        data_rdata = $urandom;
        #1;
        chk("gap_req", {31'h0, data_req}, 32'h0);
        chk("gap_stall", {31'h0, stallM}, 32'h0);
        chk("gap_rdata", readdataM, last_rdata);
    endtask

    initial begin
        resetn = 1'b0; memenM = 1'b1; memwenM = 4'h0; sizeM = 2'b10; addrM = 32'h0;
        realwdataM = 32'h0; flushM = 1'b0; pipe_stall = 1'b0;
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        #2;
        chk("rst_req", {31'h0, data_req}, 32'h0);
        chk("rst_stall", {31'h0, stallM}, 32'h0);
        chk("rst_rdata", readdataM, 32'h0);
        cyc();
        resetn = 1'b1; memenM = 1'b0; data_data_ok = 1'b0;
        gap();

        // Word load, addr_ok immediately, data_ok two cycles later.
        do_txn(4'h0, 32'h0000_1004, 2'b10, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 1'b0);
        gap();
        gap();

        // Byte store with addr_ok delayed three cycles while M inputs wander.
        do_txn(4'b0100, 32'h0000_2002, 2'b00, 32'h00AB_0000, 32'h5555_AAAA, 3, 0, 0, 1'b0);
        gap();

        // Completion while the rest of the pipeline stays frozen.
        do_txn(4'h0, 32'h0000_3000, 2'b01, 32'h0, 32'hCAFE_F00D, 0, 0, 4, 1'b0);
        gap();

        // Flushed instruction in IDLE never issues.
        cyc();
        memenM = 1'b1; flushM = 1'b1; data_addr_ok = 1'b1; data_data_ok = 1'b0;
        #1;
        chk("flush_req", {31'h0, data_req}, 32'h0);
        chk("flush_stall", {31'h0, stallM}, 32'h0);
        gap();

        // Flush raised after presentation: request still completes.
        do_txn(4'h0, 32'h0000_4008, 2'b10, 32'h0, 32'h0BAD_CAFE, 2, 1, 0, 1'b1);
        gap();

        // Reset in the middle of the data phase.
        cyc();
        memenM = 1'b1; memwenM = 4'h0; addrM = 32'h0000_5000; flushM = 1'b0;
        pipe_stall = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b0;
        #1;
        chk("prerst_req", {31'h0, data_req}, 32'h1);
        cyc();
        data_addr_ok = 1'b0;
        resetn = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
        #1;
        chk("midrst_req", {31'h0, data_req}, 32'h0);
        chk("midrst_stall", {31'h0, stallM}, 32'h0);
        chk("midrst_rdata", readdataM, 32'h0);
        cyc();
        resetn = 1'b1; memenM = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h8888_8888;
        #1;
        chk("postrst_rdata", readdataM, 32'h0);
        chk("postrst_stall", {31'h0, stallM}, 32'h0);
        last_rdata = 32'h0;
        gap();

        // Back-to-back loads, both with immediate handshakes.
        do_txn(4'h0, 32'h0000_6000, 2'b10, 32'h0, 32'h1111_2222, 0, 0, 0, 1'b0);
        do_txn(4'h0, 32'h0000_6004, 2'b10, 32'h0, 32'h3333_4444, 0, 0, 0, 1'b0);
        gap();

        for (int n = 0; n < 40; n++) begin
            logic [3:0] ws;
            ws = 1'($urandom) ? 4'($urandom_range(1, 15)) : 4'h0;
            do_txn(ws, $urandom, 2'($urandom_range(0, 2)), $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom));
            if ($urandom_range(0, 1) == 1) gap();
        end
        gap();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
